// File: rtl/vga_sync_decoder.sv
// VGA sync receiver: recovers beam position from active-low hsync/vsync,
// validates line timing and reports lock and the visible-window coordinates.
module vga_sync_decoder #(
   parameter int N          = 9,
   parameter int H_TOTAL    = 800,
   parameter int HSYNC_W    = 96,
   parameter int H_BP       = 48,
   parameter int H_ACTIVE   = 640,
   parameter int V_TOTAL    = 525,
   parameter int VSYNC_W    = 2,
   parameter int V_BP       = 33,
   parameter int V_ACTIVE   = 480,
   parameter int LOCK_LINES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hsync,
   input  logic       vsync,
   output logic [N:0] countH,
   output logic [N:0] countV,
   output logic [N:0] x,
   output logic [N:0] y,
   output logic       active,
   output logic       locked,
   output logic       err
);

   localparam int CW   = N + 1;
   localparam int HW   = $clog2(2 * H_TOTAL + 1);
   localparam int LW   = $clog2(LOCK_LINES + 1);
   localparam int CMAX = (1 << CW) - 1;
   localparam int HS   = HSYNC_W + H_BP;
   localparam int HE   = HS + H_ACTIVE;
   localparam int VS   = VSYNC_W + V_BP;
   localparam int VE   = VS + V_ACTIVE;

   typedef enum logic [1:0] {
      SEARCH,
      TRACK,
      LOCKED
   } state_t;

   state_t          state, state_n;
   logic            hs_q, vs_q, vs_n;
   logic [HW-1:0]   hcnt, hcnt_n, hcnt_inc;
   logic [HW-1:0]   lowcnt, lowcnt_n;
   logic            wok, wok_n;
   logic [LW-1:0]   good, good_n;
   logic [CW-1:0]   ch_n, cv_n, x_n, y_n;
   logic            act_n, lk_n, err_n;
   logic            fall, rise, line_ok, in_h, in_v;

   assign fall     = hs_q & ~hsync;
   assign rise     = ~hs_q & hsync;
   assign hcnt_inc = hcnt + HW'(1);
   assign line_ok  = (32'(hcnt) == H_TOTAL - 1) && wok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= SEARCH;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
         hcnt   <= '0;
         lowcnt <= '0;
         wok    <= 1'b0;
         good   <= '0;
         countH <= '0;
         countV <= '0;
         x      <= '0;
         y      <= '0;
         active <= 1'b0;
         locked <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         hs_q   <= hsync;
         vs_q   <= vs_n;
         hcnt   <= hcnt_n;
         lowcnt <= lowcnt_n;
         wok    <= wok_n;
         good   <= good_n;
         countH <= ch_n;
         countV <= cv_n;
         x      <= x_n;
         y      <= y_n;
         active <= act_n;
         locked <= lk_n;
         err    <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      vs_n     = vs_q;
      hcnt_n   = hcnt;
      lowcnt_n = lowcnt;
      wok_n    = wok;
      good_n   = good;
      cv_n     = countV;
      err_n    = 1'b0;

      // sync pulse width is measured independently of the lock state
      if (fall)
         lowcnt_n = HW'(1);
      else if (!hs_q && !hsync && lowcnt != '1)
         lowcnt_n = lowcnt + HW'(1);
      if (rise)
         wok_n = (32'(lowcnt) == HSYNC_W);
      if (fall)
         vs_n = vsync;

      unique case (state)
         SEARCH: begin
            hcnt_n = '0;
            cv_n   = '0;
            if (fall) begin
               state_n = TRACK;
               good_n  = '0;
            end
         end
         TRACK, LOCKED: begin
            if (fall) begin
               hcnt_n = '0;
               if (!vsync && vs_q) begin
                  cv_n = '0;
               end else if (32'(countV) == V_TOTAL - 1) begin
                  cv_n  = '0;
                  err_n = 1'b1;
               end else begin
                  cv_n = countV + CW'(1);
               end
               if (!line_ok) begin
                  state_n = TRACK;
                  good_n  = '0;
                  err_n   = 1'b1;
               end else if (state == TRACK) begin
                  good_n = good + LW'(1);
                  if (32'(good) == LOCK_LINES - 1)
                     state_n = LOCKED;
               end
            end else if (32'(hcnt_inc) == 2 * H_TOTAL) begin
               // no line start for two line periods: drop back to search
               state_n = SEARCH;
               hcnt_n  = '0;
               cv_n    = '0;
               good_n  = '0;
               err_n   = 1'b1;
            end else begin
               hcnt_n = hcnt_inc;
            end
         end
         default: begin
            state_n = SEARCH;
            hcnt_n  = '0;
            cv_n    = '0;
            good_n  = '0;
         end
      endcase

      lk_n  = (state_n == LOCKED);
      ch_n  = (32'(hcnt_n) > CMAX) ? '1 : CW'(hcnt_n);
      in_h  = (32'(hcnt_n) >= HS) && (32'(hcnt_n) < HE);
      in_v  = (32'(cv_n) >= VS) && (32'(cv_n) < VE);
      act_n = lk_n && in_h && in_v;
      x_n   = act_n ? CW'(32'(hcnt_n) - HS) : '0;
      y_n   = act_n ? CW'(32'(cv_n) - VS) : '0;
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: generated sync stream, per-cycle scoreboard
// plus scenario spot checks.
module tb_vga_sync_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       hsync, vsync;
   logic [9:0] countH, countV, x, y;
   logic       active, locked, err;

   vga_sync_decoder dut (
      .clk    (clk),
      .rst    (rst),
      .hsync  (hsync),
      .vsync  (vsync),
      .countH (countH),
      .countV (countV),
      .x      (x),
      .y      (y),
      .active (active),
      .locked (locked),
      .err    (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] h, v, x, y;
      logic       a, l, e;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   int gv, good;
   bit srch, lk, prev_ok;

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            checks += 7;
            if (countH !== e.h) begin
               errors++;
               $display("FAIL sb_countH t=%0t got %0d exp %0d", $time, countH, e.h);
            end
            if (countV !== e.v) begin
               errors++;
               $display("FAIL sb_countV t=%0t got %0d exp %0d", $time, countV, e.v);
            end
            if (x !== e.x) begin
               errors++;
               $display("FAIL sb_x t=%0t got %0d exp %0d", $time, x, e.x);
            end
            if (y !== e.y) begin
               errors++;
               $display("FAIL sb_y t=%0t got %0d exp %0d", $time, y, e.y);
            end
            if (active !== e.a) begin
               errors++;
               $display("FAIL sb_active t=%0t got %b exp %b", $time, active, e.a);
            end
            if (locked !== e.l) begin
               errors++;
               $display("FAIL sb_locked t=%0t got %b exp %b", $time, locked, e.l);
            end
            if (err !== e.e) begin
               errors++;
               $display("FAIL sb_err t=%0t got %b exp %b", $time, err, e.e);
            end
         end
      end
   end

   // drive cycles c0..c1 of a line of length len with an hsync low of loww
   task automatic run_seg(input int len, input int loww,
                          input int c0, input int c1);
      exp_t e;
      bit   ee, act;
      for (int c = c0; c <= c1; c++) begin
         @(negedge clk);
         if (c == 0) begin
            if (srch) begin
               srch = 0;
               gv   = 0;
               good = 0;
               ee   = 0;
            end else if (prev_ok) begin
               ee = 0;
               if (!lk) begin
                  good++;
                  if (good == 4) lk = 1;
               end
            end else begin
               ee   = 1;
               good = 0;
               lk   = 0;
            end
         end else if (!srch && c == 1600) begin
            srch = 1;
            lk   = 0;
            good = 0;
            ee   = 1;
         end else begin
            ee = 0;
         end
         hsync = (c < loww) ? 1'b0 : 1'b1;
         vsync = (gv < 2) ? 1'b0 : 1'b1;
         act = lk && !srch && c >= 144 && c < 784 && gv >= 35 && gv < 515;
         e.h = srch ? 10'd0 : ((c > 1023) ? 10'd1023 : 10'(c));
         e.v = srch ? 10'd0 : 10'(gv);
         e.x = act ? 10'(c - 144) : 10'd0;
         e.y = act ? 10'(gv - 35) : 10'd0;
         e.a = act;
         e.l = lk;
         e.e = ee;
         q.push_back(e);
         if (!srch && c == len - 1) begin
            prev_ok = (len == 800 && loww == 96);
            gv = (gv + 1) % 525;
         end
      end
   endtask

   task automatic run_line(input int len, input int loww);
      run_seg(len, loww, 0, len - 1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      hsync = 1'b1;
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      checks += 7;
      if (countH !== 10'd0) begin errors++; $display("FAIL rst_countH got %0d exp 0", countH); end
      if (countV !== 10'd0) begin errors++; $display("FAIL rst_countV got %0d exp 0", countV); end
      if (x !== 10'd0) begin errors++; $display("FAIL rst_x got %0d exp 0", x); end
      if (y !== 10'd0) begin errors++; $display("FAIL rst_y got %0d exp 0", y); end
      if (active !== 1'b0) begin errors++; $display("FAIL rst_active got %b exp 0", active); end
      if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b exp 0", locked); end
      if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
      rst = 1'b0;
   endtask

   task automatic relock_check(input string tag);
      repeat (3) run_line(800, 96);
      run_seg(800, 96, 0, 799);
      @(posedge clk); #2;
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL %s_early got locked=%b exp 0", tag, locked);
      end
      run_seg(800, 96, 0, 0);
      @(posedge clk); #2;
      checks += 2;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL %s_lock got locked=%b exp 1", tag, locked);
      end
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL %s_lock_err got err=%b exp 0", tag, err);
      end
      run_seg(800, 96, 1, 799);
   endtask

   task automatic test_nominal_lock;
      relock_check("nominal");
   endtask

   task automatic test_active_window;
      while (gv != 35) run_line(800, 96);
      run_seg(800, 96, 0, 143);
      @(posedge clk); #2;
      checks++;
      if (active !== 1'b0) begin errors++; $display("FAIL win_143 active=%b exp 0", active); end
      run_seg(800, 96, 144, 144);
      @(posedge clk); #2;
      checks += 3;
      if (active !== 1'b1) begin errors++; $display("FAIL win_144 active=%b exp 1", active); end
      if (x !== 10'd0) begin errors++; $display("FAIL win_144_x got %0d exp 0", x); end
      if (y !== 10'd0) begin errors++; $display("FAIL win_144_y got %0d exp 0", y); end
      run_seg(800, 96, 145, 783);
      @(posedge clk); #2;
      checks += 2;
      if (x !== 10'd639) begin errors++; $display("FAIL win_783_x got %0d exp 639", x); end
      if (active !== 1'b1) begin errors++; $display("FAIL win_783 active=%b exp 1", active); end
      run_seg(800, 96, 784, 784);
      @(posedge clk); #2;
      checks += 2;
      if (active !== 1'b0) begin errors++; $display("FAIL win_784 active=%b exp 0", active); end
      if (x !== 10'd0) begin errors++; $display("FAIL win_784_x got %0d exp 0", x); end
      run_seg(800, 96, 785, 799);
   endtask

   task automatic test_short_line;
      run_line(799, 96);
      run_seg(800, 96, 0, 0);
      @(posedge clk); #2;
      checks += 2;
      if (err !== 1'b1) begin errors++; $display("FAIL short_err got %b exp 1", err); end
      if (locked !== 1'b0) begin errors++; $display("FAIL short_locked got %b exp 0", locked); end
      run_seg(800, 96, 1, 1);
      @(posedge clk); #2;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL short_pulse got err=%b exp 0", err); end
      run_seg(800, 96, 2, 799);
      repeat (3) run_line(800, 96);
      run_seg(800, 96, 0, 0);
      @(posedge clk); #2;
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL short_relock got %b exp 1", locked); end
      run_seg(800, 96, 1, 799);
   endtask

   task automatic test_narrow_pulse;
      run_line(800, 95);
      run_seg(800, 96, 0, 0);
      @(posedge clk); #2;
      checks += 2;
      if (err !== 1'b1) begin errors++; $display("FAIL narrow_err got %b exp 1", err); end
      if (locked !== 1'b0) begin errors++; $display("FAIL narrow_locked got %b exp 0", locked); end
      run_seg(800, 96, 1, 799);
      repeat (3) run_line(800, 96);
      run_seg(800, 96, 0, 0);
      @(posedge clk); #2;
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL narrow_relock got %b exp 1", locked); end
      run_seg(800, 96, 1, 799);
   endtask

   task automatic test_timeout;
      run_seg(2000, 96, 0, 1599);
      @(posedge clk); #2;
      checks++;
      if (countH !== 10'd1023) begin errors++; $display("FAIL to_sat got %0d exp 1023", countH); end
      run_seg(2000, 96, 1600, 1600);
      @(posedge clk); #2;
      checks += 3;
      if (err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", err); end
      if (locked !== 1'b0) begin errors++; $display("FAIL to_locked got %b exp 0", locked); end
      if (countH !== 10'd0) begin errors++; $display("FAIL to_countH got %0d exp 0", countH); end
      run_seg(2000, 96, 1601, 1650);
      @(posedge clk); #2;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL to_hold_err got %b exp 0", err); end
      relock_check("timeout");
   endtask

   task automatic test_reset_mid_frame;
      run_seg(800, 96, 0, 400);
      @(posedge clk); #2;
      checks++;
      if (countH !== 10'd400) begin errors++; $display("FAIL mid_pre got %0d exp 400", countH); end
      #1 rst = 1'b1;
      #1;
      checks += 4;
      if (countH !== 10'd0) begin errors++; $display("FAIL mid_countH got %0d exp 0", countH); end
      if (countV !== 10'd0) begin errors++; $display("FAIL mid_countV got %0d exp 0", countV); end
      if (locked !== 1'b0) begin errors++; $display("FAIL mid_locked got %b exp 0", locked); end
      if (x !== 10'd0 || y !== 10'd0 || active !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL mid_outs got x=%0d y=%0d a=%b e=%b exp 0", x, y, active, err);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      srch = 1;
      lk = 0;
      good = 0;
      prev_ok = 0;
      relock_check("mid");
   endtask

   initial begin
      srch = 1;
      lk = 0;
      good = 0;
      gv = 0;
      prev_ok = 0;
      test_reset();
      test_nominal_lock();
      test_active_window();
      test_short_line();
      test_narrow_pulse();
      test_timeout();
      test_reset_mid_frame();
      @(posedge clk); #3;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got %0d left exp 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receiver side of the VGA sync interface. Consumes active-low hsync/vsync produced by the horizontal/vertical counter-and-comparator chain (sync low while count < sync width) and recovers the beam position. It validates line timing, locks after consecutive good lines, and outputs pixel coordinates with an active-video flag. It sits in front of frame-capture and verification logic, one pixel clock per cycle.

Parameters:
N, 9, counter MSB index; all count ports are [N:0].
H_TOTAL, 800, pixel clocks per line.
HSYNC_W, 96, hsync low width in clocks.
H_BP, 48, horizontal back porch.
H_ACTIVE, 640, visible pixels per line.
V_TOTAL, 525, lines per frame.
VSYNC_W, 2, vsync low width in lines.
V_BP, 33, vertical back porch.
V_ACTIVE, 480, visible lines.
LOCK_LINES, 4, consecutive good lines needed to lock.

Ports:
clk  input  1  pixel clock; one clock only.
rst  input  1  asynchronous, active-high reset.
hsync  input  1  active-low horizontal sync, synchronous to clk.
vsync  input  1  active-low vertical sync, synchronous to clk.
countH  output  N+1  recovered horizontal count; 0 at the first hsync-low cycle.
countV  output  N+1  recovered line count; 0 on the first line with vsync low.
x  output  N+1  active pixel column; 0 when not active.
y  output  N+1  active pixel row; 0 when not active.
active  output  1  high when locked and inside the visible window.
locked  output  1  timing lock status.
err  output  1  one-cycle pulse on a timing violation.

Behaviour:
- Reset (async, rst=1): all outputs 0; state SEARCH; internal hs_q/vs_q = 1; good-line count 0.
- Edge detect: hs_q registers hsync. A falling edge is hs_q=1 && hsync=0. All outputs are registered. Latency is 1 clock: the clock after the edge that first samples hsync low, countH = 0.
- countH increments by 1 every clock and restarts at 0 on each falling edge. It saturates at 2^(N+1)-1 and never wraps.
- Pulse width: counts clocks hsync is low. At the rising edge, compare to HSYNC_W.
- Line length: at each falling edge, length = countH+1 and must equal H_TOTAL. A line is good only if length and width both match.
- countV:
  - Increments at each hsync falling edge.
  - Resets to 0 at an hsync falling edge where vsync=0 and vs_q (vsync sampled at the previous hsync falling edge) = 1.
  - If countV would reach V_TOTAL without a vsync, it resets to 0 and err pulses.
- State machine:
  - SEARCH → TRACK on the first falling edge. That edge is not length-checked; good count = 0.
  - TRACK: a good line increments the good count; a bad line clears it and pulses err. Reaching LOCK_LINES moves to LOCKED, and locked=1 with the same registered update.
  - LOCKED: a bad line → TRACK, locked=0, err=1, good count = 0.
  - Any state: countH reaching 2*H_TOTAL with no falling edge → SEARCH, locked=0, err=1, counters hold 0.
- Active window:
  - active = locked && HSYNC_W+H_BP ≤ countH < HSYNC_W+H_BP+H_ACTIVE && VSYNC_W+V_BP ≤ countV < VSYNC_W+V_BP+V_ACTIVE.
  - x = countH-(HSYNC_W+H_BP) and y = countV-(VSYNC_W+V_BP) when active, else 0. Same registered cycle as countH.
- Simultaneous events: a timeout and a falling edge in the same cycle count as the edge (no timeout). A bad line and reaching LOCK_LINES cannot coincide; a bad line has priority.
- Reset mid-frame: immediate return to the reset values; re-lock requires a SEARCH→TRACK→LOCKED pass.

Test Plan:
- Nominal 640x480 stream from reset → locked rises the clock after the 5th hsync falling edge (1 SEARCH edge + 4 good lines); err never pulses.
- Locked, frame running → at countH=144, countV=35: active=1, x=0, y=0. At countH=783: x=639. At countH=784: active=0, x=0.
- Locked, inject one 799-clock line → err pulses one cycle at that edge, locked=0; re-locks after 4 further good lines.
- Locked, hsync low for 95 clocks on one line → err at the falling edge that ends that line, state TRACK, locked=0.
- Hsync held high after lock → at countH=1600: err=1, locked=0, countH=0, state SEARCH; the next falling edge enters TRACK.
- Assert rst at countH=400 mid-frame → all outputs 0 asynchronously. After release, the nominal stream re-locks per scenario 1.
